// File: rtl/piece_x_pkg.sv
// ---------------------------------------------------------------
// piece_x_pkg : shared widths and FSM encoding for piece motion
// Revision    : 1.0
// ---------------------------------------------------------------
`default_nettype none

package piece_x_pkg;
  localparam int COLS = 10;
  localparam int X_W  = 4;
  localparam int PW_W = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ERASE  = 3'd2;
  localparam logic [2:0] S_WAIT_E = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DRAW   = 3'd5;
  localparam logic [2:0] S_WAIT_D = 3'd6;
  localparam logic [2:0] S_ACK    = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    CHECK  = S_CHECK,
    ERASE  = S_ERASE,
    WAIT_E = S_WAIT_E,
    UPDATE = S_UPDATE,
    DRAW   = S_DRAW,
    WAIT_D = S_WAIT_D,
    ACK    = S_ACK
  } state_t;
endpackage

`default_nettype wire

// File: rtl/piece_x_ctrl_bounds.sv
// ---------------------------------------------------------------
// piece_x_bounds : decides whether a requested one-column move is legal
// Revision       : 1.0
// ---------------------------------------------------------------
`default_nettype none

module piece_x_bounds
  import piece_x_pkg::*;
#(
  parameter int COLS_P = COLS,
  parameter int X_W_P  = X_W,
  parameter int PW_W_P = PW_W
) (
  input  logic [X_W_P-1:0]  x_pos,
  input  logic [PW_W_P-1:0] piece_w,
  input  logic              req_l,
  input  logic              req_r,
  input  logic              blocked_l,
  input  logic              blocked_r,
  output logic              legal,
  output logic              dir
);

  // One extra bit so the right edge sum can never wrap.
  logic [X_W_P:0] right_edge;
  logic           ok_l;
  logic           ok_r;

  assign right_edge = {1'b0, x_pos} + (X_W_P+1)'(piece_w);
  assign ok_l       = (x_pos != '0) && !blocked_l;
  assign ok_r       = (right_edge < (X_W_P+1)'(COLS_P)) && !blocked_r;
  assign legal      = (req_l ^ req_r) && (req_l ? ok_l : ok_r);
  assign dir        = req_r;

endmodule

`default_nettype wire

// File: rtl/piece_x_ctrl.sv
// ---------------------------------------------------------------
// piece_x_ctrl : applies left/right requests to the piece column and
//                sequences erase/redraw through the draw engine
// Revision     : 1.0
// ---------------------------------------------------------------
`default_nettype none

module piece_x_ctrl
  import piece_x_pkg::*;
#(
  parameter int COLS_P = COLS,
  parameter int X_W_P  = X_W,
  parameter int PW_W_P = PW_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        move_l,
  input  logic [3:0]        move_r,
  input  logic              spawn,
  input  logic [X_W_P-1:0]  spawn_x,
  input  logic [PW_W_P-1:0] piece_w,
  input  logic              blocked_l,
  input  logic              blocked_r,
  input  logic              draw_done,
  output logic [X_W_P-1:0]  x_pos,
  output logic              draw_req,
  output logic              erase,
  output logic              already_moved,
  output logic              busy
);

  state_t state;
  logic   req_l;
  logic   req_r;
  logic   legal;
  logic   dir;
  logic   dir_right;

  assign req_l = |move_l;
  assign req_r = |move_r;

  piece_x_bounds #(
    .COLS_P (COLS_P),
    .X_W_P  (X_W_P),
    .PW_W_P (PW_W_P)
  ) u_bounds (
    .x_pos     (x_pos),
    .piece_w   (piece_w),
    .req_l     (req_l),
    .req_r     (req_r),
    .blocked_l (blocked_l),
    .blocked_r (blocked_r),
    .legal     (legal),
    .dir       (dir)
  );

  // Outputs are set on the edge entering each state so they line up with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      x_pos         <= '0;
      draw_req      <= 1'b0;
      erase         <= 1'b0;
      already_moved <= 1'b0;
      busy          <= 1'b0;
      dir_right     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (spawn) begin
            x_pos <= spawn_x;
          end else if (req_l || req_r) begin
            state <= CHECK;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (legal) begin
            state     <= ERASE;
            draw_req  <= 1'b1;
            erase     <= 1'b1;
            dir_right <= dir;
          end else begin
            state         <= ACK;
            already_moved <= 1'b1;
          end
        end
        ERASE: begin
          draw_req <= 1'b0;
          state    <= WAIT_E;
        end
        WAIT_E: begin
          if (draw_done) begin
            erase <= 1'b0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          x_pos    <= dir_right ? x_pos + X_W_P'(1) : x_pos - X_W_P'(1);
          draw_req <= 1'b1;
          state    <= DRAW;
        end
        DRAW: begin
          draw_req <= 1'b0;
          state    <= WAIT_D;
        end
        WAIT_D: begin
          if (draw_done) begin
            already_moved <= 1'b1;
            state         <= ACK;
          end
        end
        ACK: begin
          // The upstream latch clears once it sees the acknowledge.
          if (!req_l && !req_r) begin
            already_moved <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piece_x_ctrl.sv
// ---------------------------------------------------------------
// tb_piece_x_ctrl : directed and randomized checks of piece_x_ctrl
// Revision        : 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_piece_x_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] move_l = '0;
  logic [3:0] move_r = '0;
  logic       spawn = 1'b0;
  logic [3:0] spawn_x = '0;
  logic [2:0] piece_w = 3'd1;
  logic       blocked_l = 1'b0;
  logic       blocked_r = 1'b0;
  logic       draw_done = 1'b0;
  logic [3:0] x_pos;
  logic       draw_req;
  logic       erase;
  logic       already_moved;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cur_x = 0;
  int lat = 3;
  int n_req = 0;
  int dcnt = 0;
  int log_erase [0:1023];
  int log_x [0:1023];

  piece_x_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .move_l        (move_l),
    .move_r        (move_r),
    .spawn         (spawn),
    .spawn_x       (spawn_x),
    .piece_w       (piece_w),
    .blocked_l     (blocked_l),
    .blocked_r     (blocked_r),
    .draw_done     (draw_done),
    .x_pos         (x_pos),
    .draw_req      (draw_req),
    .erase         (erase),
    .already_moved (already_moved),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Draw engine stand-in: logs each request and answers after lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      draw_done = 1'b0;
      if (!resetn) begin
        dcnt = 0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) draw_done = 1'b1;
        end
        if (draw_req) begin
          log_erase[n_req % 1024] = int'(erase);
          log_x[n_req % 1024]     = int'(x_pos);
          n_req++;
          dcnt = lat;
        end
      end
    end
  end

  task automatic do_spawn(input int v);
    spawn_x = 4'(v);
    spawn   = 1'b1;
    @(negedge clk);
    spawn   = 1'b0;
    chk("spawn_x_pos", int'(x_pos), v);
    chk("spawn_busy", int'(busy), 0);
    cur_x = v;
  endtask

  task automatic wait_ack();
    int to;
    to = 0;
    while (!already_moved && to < 200) begin
      @(negedge clk);
      to++;
    end
    chk("ack_seen", int'(already_moved), 1);
  endtask

  task automatic do_move(input logic [3:0] ml, input logic [3:0] mr, input int w,
                         input logic bl, input logic br);
    int  exp_x;
    int  start;
    bit  moved;
    exp_x = cur_x;
    moved = 0;
    if ((ml != 0) && (mr == 0) && cur_x > 0 && !bl) begin
      exp_x = cur_x - 1; moved = 1;
    end else if ((mr != 0) && (ml == 0) && (cur_x + w < 10) && !br) begin
      exp_x = cur_x + 1; moved = 1;
    end
    piece_w   = 3'(w);
    blocked_l = bl;
    blocked_r = br;
    start     = n_req;
    move_l    = ml;
    move_r    = mr;
    wait_ack();
    chk("x_pos", int'(x_pos), exp_x);
    chk("draw_count", n_req - start, moved ? 2 : 0);
    chk("busy_in_ack", int'(busy), 1);
    if (moved) begin
      chk("req1_erase", log_erase[start % 1024], 1);
      chk("req1_x", log_x[start % 1024], cur_x);
      chk("req2_erase", log_erase[(start + 1) % 1024], 0);
      chk("req2_x", log_x[(start + 1) % 1024], exp_x);
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("ack_hold", int'(already_moved), 1);
    end
    move_l = '0;
    move_r = '0;
    @(negedge clk);
    chk("ack_release", int'(already_moved), 0);
    chk("idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("idle_draw_req", int'(draw_req), 0);
    blocked_l = 1'b0;
    blocked_r = 1'b0;
    cur_x = exp_x;
  endtask

  initial begin
    int to;
    logic [3:0] ml;
    logic [3:0] mr;
    int sel;

    repeat (3) @(negedge clk);
    chk("rst_x_pos", int'(x_pos), 0);
    chk("rst_draw_req", int'(draw_req), 0);
    chk("rst_erase", int'(erase), 0);
    chk("rst_ack", int'(already_moved), 0);
    chk("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    @(negedge clk);

    do_spawn(4);
    do_move(4'd10, 4'd0, 2, 1'b0, 1'b0);
    do_spawn(0);
    do_move(4'd10, 4'd0, 2, 1'b0, 1'b0);
    do_spawn(6);
    do_move(4'd0, 4'd10, 4, 1'b0, 1'b0);
    do_spawn(5);
    do_move(4'd0, 4'd10, 4, 1'b0, 1'b0);
    do_move(4'd10, 4'd10, 1, 1'b0, 1'b0);
    do_spawn(3);
    do_move(4'd0, 4'd10, 1, 1'b0, 1'b1);
    do_move(4'd10, 4'd0, 1, 1'b1, 1'b0);

    // Reset while waiting on the erase completion.
    do_spawn(5);
    lat   = 6;
    to    = n_req;
    move_l = 4'd10;
    while (n_req == to && n_req - to < 1000 && checks < 100000) begin
      @(negedge clk);
      if (n_req == to && busy == 1'b0 && already_moved == 1'b1) break;
    end
    @(negedge clk);
    chk("pre_rst_erase", int'(erase), 1);
    resetn = 1'b0;
    #1;
    chk("midrst_ack", int'(already_moved), 0);
    chk("midrst_draw_req", int'(draw_req), 0);
    chk("midrst_x_pos", int'(x_pos), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    resetn = 1'b1;
    lat    = 3;
    cur_x  = 0;
    do_spawn(2);
    do_move(4'd10, 4'd0, 1, 1'b0, 1'b0);
    chk("post_rst_x_pos", int'(x_pos), 1);

    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) do_spawn($urandom_range(0, 9));
      sel = $urandom_range(0, 5);
      ml  = 4'($urandom_range(1, 15));
      mr  = 4'($urandom_range(1, 15));
      if (sel < 2) mr = '0;
      else if (sel < 4) ml = '0;
      do_move(ml, mr, $urandom_range(1, 4),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/piece_x_ctrl.md
Name: piece_x_ctrl

Overview:
- Consumes the latched left/right move requests (move_l, move_r) and applies them to the falling piece's column position.
- Sequences the erase/redraw of the piece through the VGA draw engine.
- Returns the already_moved acknowledge that clears the request latches.
- Sits between the move-request latch and the draw engine / board-occupancy logic.

Parameters:
COLS, 10, board width in columns
X_W, 4, width of column index (must satisfy 2^X_W >= COLS)
PW_W, 3, width of piece-width field

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
move_l  input  4  left request; any nonzero value = request pending
move_r  input  4  right request; any nonzero value = request pending
spawn  input  1  one-cycle pulse: new piece appears, load spawn_x
spawn_x  input  X_W  spawn column of new piece
piece_w  input  PW_W  current piece width in columns (1..4)
blocked_l  input  1  board cell left of piece occupied (from occupancy logic)
blocked_r  input  1  board cell right of piece occupied
draw_done  input  1  one-cycle pulse from draw engine: requested erase/draw finished
x_pos  output  X_W  current leftmost column of piece
draw_req  output  1  one-cycle pulse: start draw-engine operation
erase  output  1  qualifies draw_req: 1 = erase at x_pos, 0 = draw at x_pos
already_moved  output  1  acknowledge to request latch, level, 4-phase
busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk; resetn asynchronous active-low. Reset values: x_pos=0, draw_req=0, erase=0, already_moved=0, busy=0, FSM=IDLE.
- Request decode: req_l = |move_l, req_r = |move_r. Sampled only in IDLE.
- States: IDLE, CHECK, ERASE, WAIT_E, UPDATE, DRAW, WAIT_D, ACK.
- IDLE:
  - spawn has priority: x_pos<=spawn_x; stay in IDLE.
  - else if req_l or req_r -> CHECK.
- CHECK (one cycle):
  - Compute legal = (req_l xor req_r) and direction not blocked and in bounds.
  - Left in bounds: x_pos != 0 and !blocked_l.
  - Right in bounds: x_pos + piece_w < COLS and !blocked_r (compute at X_W+1 bits; no wrap).
  - legal -> ERASE. Illegal, or both req_l and req_r -> ACK, with no redraw and x_pos unchanged.
- ERASE: draw_req=1, erase=1 for exactly one cycle -> WAIT_E.
- WAIT_E: hold erase=1 until draw_done -> UPDATE.
- UPDATE: x_pos <= x_pos-1 (left) or x_pos+1 (right); direction latched in CHECK -> DRAW.
- DRAW: draw_req=1, erase=0 for one cycle -> WAIT_D.
- WAIT_D: wait for draw_done -> ACK.
- ACK:
  - already_moved=1.
  - Hold until move_l==0 and move_r==0 (the latch clears asynchronously on the acknowledge), then deassert already_moved and return to IDLE in the next cycle.
  - Guarantees already_moved is high for at least 1 cycle.
- Latency: legal move takes 4 cycles plus both draw-engine latencies to reach ACK. x_pos changes exactly at the UPDATE edge.
- spawn outside IDLE is ignored. The board controller must only issue spawn while busy=0.
- draw_done outside WAIT_E/WAIT_D is ignored.
- Reset mid-operation: FSM returns to IDLE and already_moved drops immediately. The pending request remains latched upstream and is serviced after reset.
- A new request arriving during ACK is lost only if it arrives before the latch clears. This is acceptable: the user presses again.

Decomposition:
- Shared package holds the FSM state encoding (3-bit localparams), COLS, and X_W, so the board controller and draw engine use identical widths.
- The bounds/legality check is natural as a sub-module: piece_x_bounds (combinational: x_pos, piece_w, req_l, req_r, blocked_l, blocked_r -> legal, dir).

Test Plan:
1. Reset with resetn=0 -> all outputs 0. Then spawn pulse with spawn_x=4 -> x_pos=4, busy=0.
2. x_pos=4, move_l=10; bench returns draw_done 3 cycles after each draw_req -> erase draw_req then draw draw_req, x_pos=3, already_moved=1. Bench clears move_l -> already_moved=0, FSM IDLE.
3. x_pos=0, move_l=10 -> no draw_req, x_pos stays 0, already_moved asserted then released after move_l=0.
4. x_pos=6, piece_w=4, move_r=10 -> 6+4=10 is not <10, so blocked, x_pos=6, no draw_req. Same case with x_pos=5 -> x_pos=6 after redraw.
5. move_l=10 and move_r=10 together -> no move, single already_moved acknowledge clears both. Separately, blocked_r=1 with move_r=10 -> no move.
6. resetn pulled low while in WAIT_E -> already_moved=0, draw_req=0, x_pos=0 immediately. After release with move_l still 10 and a prior spawn_x=2 -> move executes, x_pos=1.
